// File: rtl/hv_mem_reader.sv
// Read initiator for the single-port hypervector RAM: streams `length` words from
// `base_addr` onto a valid/ready output through a small credit-checked FIFO.
module hv_mem_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int OW = PW + 1;
  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [OW:0] DEPTH_C = (OW+1)'(BUF_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [LW-1:0]           len_q, len_d;
  logic [LW-1:0]           issued_q, issued_d;
  logic [LW-1:0]           capt_q, capt_d;
  logic                    pend_q, pend_d;
  logic                    last_sent_q, last_sent_d;
  logic [OW-1:0]           occ_q, occ_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0]   data_mem_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0]   data_mem_d [BUF_DEPTH];
  logic                    last_mem_q [BUF_DEPTH];
  logic                    last_mem_d [BUF_DEPTH];

  logic [OW:0]             credit_s;
  logic                    issue_s;
  logic                    pop_s;
  logic                    head_last_s;
  logic                    last_done_s;

  // Next-state logic: read issue, FIFO push/pop and command sequencing.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    issued_d    = issued_q;
    capt_d      = capt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    data_mem_d  = data_mem_q;
    last_mem_d  = last_mem_q;

    // A pop in this cycle deliberately does not free a credit until next cycle.
    credit_s    = {1'b0, occ_q} + (OW+1)'(pend_q);
    issue_s     = (state_q == ST_READ) && (issued_q < len_q) && (credit_s < DEPTH_C);
    pop_s       = (occ_q != {OW{1'b0}}) && out_ready;
    head_last_s = last_mem_q[rd_ptr_q];
    last_done_s = last_sent_q | (pop_s & head_last_s);
    last_sent_d = last_done_s;
    pend_d      = issue_s;
    occ_d       = occ_q + OW'(pend_q) - OW'(pop_s);

    if (pend_q) begin
      data_mem_d[wr_ptr_q] = mem_data_in;
      last_mem_d[wr_ptr_q] = (capt_q == (len_q - LW'(1)));
      wr_ptr_d             = wr_ptr_q + PW'(1);
      capt_d               = capt_q + LW'(1);
    end else begin
      capt_d               = capt_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (length != {LW{1'b0}}) begin
            state_d     = ST_READ;
            base_d      = base_addr;
            len_d       = length;
            issued_d    = {LW{1'b0}};
            capt_d      = {LW{1'b0}};
            last_sent_d = 1'b0;
          end else begin
            state_d     = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (issue_s) begin
          issued_d = issued_q + LW'(1);
          if ((issued_q + LW'(1)) == len_q) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_READ;
          end
        end else begin
          state_d = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (!pend_q && (occ_d == {OW{1'b0}}) && last_done_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      base_q      <= {ADDR_WIDTH{1'b0}};
      len_q       <= {LW{1'b0}};
      issued_q    <= {LW{1'b0}};
      capt_q      <= {LW{1'b0}};
      pend_q      <= 1'b0;
      last_sent_q <= 1'b0;
      occ_q       <= {OW{1'b0}};
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      data_mem_q  <= '{default: {DATA_WIDTH{1'b0}}};
      last_mem_q  <= '{default: 1'b0};
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      capt_q      <= capt_d;
      pend_q      <= pend_d;
      last_sent_q <= last_sent_d;
      occ_q       <= occ_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      data_mem_q  <= data_mem_d;
      last_mem_q  <= last_mem_d;
    end
  end

  // Outputs depend only on flops, so they all read 0 while reset is held.
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign mem_cs      = issue_s;
  assign mem_oe      = issue_s;
  assign mem_we      = 1'b0;
  assign mem_address = issue_s ? (base_q + issued_q[ADDR_WIDTH-1:0]) : {ADDR_WIDTH{1'b0}};
  assign out_valid   = (occ_q != {OW{1'b0}});
  assign out_data    = out_valid ? data_mem_q[rd_ptr_q] : {DATA_WIDTH{1'b0}};
  assign out_last    = out_valid & head_last_s;

endmodule

// File: tb/tb_hv_mem_reader.sv
// Scoreboard bench for hv_mem_reader: expected addresses and words are queued at
// command start and compared as the DUT issues reads and transfers words.
module tb_hv_mem_reader;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int BD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy, done;
  logic [AW-1:0] mem_address;
  logic          mem_cs, mem_we, mem_oe;
  logic [DW-1:0] mem_data_in = '0;
  logic [DW-1:0] out_data;
  logic          out_valid, out_ready, out_last;

  logic [DW-1:0] ram [256];
  logic [DW:0]   exp_q [$];
  logic [AW-1:0] addr_q [$];

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   done_cnt = 0, done_cyc = 0, xfer_total = 0;
  int   last_xfer_cyc = 0, valid_rise_cyc = 0, outst = 0;
  logic prev_valid = 1'b0;
  logic rdy_rand = 1'b0;
  int   e0 = 0, d0 = 0;

  hv_mem_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BUF_DEPTH(BD)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .mem_address(mem_address), .mem_cs(mem_cs),
    .mem_we(mem_we), .mem_oe(mem_oe), .mem_data_in(mem_data_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM model with one-cycle read latency.
  always @(posedge clk) if (mem_cs && mem_oe && !mem_we) mem_data_in <= ram[mem_address];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: compares reads and transfers against the queues, away from the clock edge.
  always @(negedge clk) begin
    check("mem_ctl", 64'({mem_we, mem_oe ^ mem_cs}), 64'd0);
    if (rst) begin
      outst      <= 0;
      prev_valid <= 1'b0;
    end else begin
      if (mem_cs) begin
        check("credit", 64'(outst < BD), 64'd1);
        check("cs_busy", 64'(busy), 64'd1);
        if (addr_q.size() == 0) begin
          check("read_unexpected", 64'(mem_cs), 64'd0);
        end else begin
          check("mem_addr", 64'(mem_address), 64'(addr_q[0]));
          void'(addr_q.pop_front());
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("xfer_unexpected", 64'(out_valid), 64'd0);
        end else begin
          check("xfer_data", 64'(out_data), 64'(exp_q[0][DW-1:0]));
          check("xfer_last", 64'(out_last), 64'(exp_q[0][DW]));
          void'(exp_q.pop_front());
        end
        xfer_total <= xfer_total + 1;
        if (out_last) last_xfer_cyc <= cyc;
      end
      if (out_valid && !prev_valid) valid_rise_cyc <= cyc;
      prev_valid <= out_valid;
      outst      <= outst + int'(mem_cs) - int'(out_valid && out_ready);
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
    end
  end

  // Downstream ready: always high, or high 30% of cycles when rdy_rand is set.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  task automatic start_cmd(input logic [AW-1:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      a = b + AW'(i);
      addr_q.push_back(a);
      exp_q.push_back({(i == n - 1), ram[a]});
    end
    d0        = done_cnt;
    start     = 1'b1;
    base_addr = b;
    length    = (AW+1)'(n);
    @(posedge clk);
    #1;
    e0    = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int n, input logic timed);
    int k;
    k = 0;
    while (done_cnt == d0 && k < 20 * n + 100) begin
      @(posedge clk);
      k++;
    end
    check("done_seen", 64'(done_cnt - d0), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    check("done_once", 64'(done_cnt - d0), 64'd1);
    check("idle_after", 64'(busy), 64'd0);
    check("sb_empty", 64'(exp_q.size() + addr_q.size()), 64'd0);
    if (timed) begin
      check("done_cyc", 64'(done_cyc - e0), (n == 0) ? 64'd0 : 64'(n + 2));
      if (n > 0) begin
        check("first_valid", 64'(valid_rise_cyc - e0), 64'd2);
        check("last_xfer", 64'(last_xfer_cyc - e0), 64'(n + 1));
      end
    end
  endtask

  initial begin
    int k;
    int x0;
    for (int a = 0; a < 256; a++) ram[a] = {8'h5A, 8'(a), 8'(~a), 8'(a ^ 8'h3C)};
    for (int i = 0; i < 4; i++) ram[8'h10 + i] = 32'h0000_0100 + 32'(i);

    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", 64'({busy, done, mem_cs, mem_oe, mem_we, mem_address, out_valid, out_last}), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    start_cmd(8'h10, 4);  wait_done(4, 1'b1);    // basic
    start_cmd(8'hFE, 4);  wait_done(4, 1'b1);    // address wrap
    start_cmd(8'h20, 0);  wait_done(0, 1'b1);    // zero length

    rdy_rand = 1'b1;
    start_cmd(8'h40, 16); wait_done(16, 1'b0);   // backpressure
    rdy_rand = 1'b0;

    start_cmd(8'h00, 256); wait_done(256, 1'b1); // full length

    // Second start while busy must be ignored.
    start_cmd(8'h30, 6);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; base_addr = 8'h90; length = 9'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_during_read", 64'(busy), 64'd1);
    wait_done(6, 1'b0);

    // Reset after three transfers of an eight-word command.
    start_cmd(8'h80, 8);
    x0 = xfer_total;
    k = 0;
    while (xfer_total - x0 < 3 && k < 100) begin
      @(posedge clk);
      k++;
    end
    check("xfers_before_rst", 64'(xfer_total - x0), 64'd3);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_outs", 64'({busy, done, mem_cs, mem_oe, mem_we, mem_address, out_valid, out_last}), 64'd0);
    check("rst_mid_data", 64'(out_data), 64'd0);
    exp_q.delete();
    addr_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("no_done_on_rst", 64'(done_cnt - d0), 64'd0);
    start_cmd(8'hC8, 5); wait_done(5, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
